// File: rtl/rr_merge_stage_pkg.sv
// Shared definitions for the round-robin merge stage: source encodings,
// the grant record and the round-robin arbitration rule.
package rr_merge_stage_pkg;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef struct packed {
        logic a;
        logic b;
    } grant_t;

    // prio names the favoured source when both request; open gates every grant.
    function automatic grant_t rr_grant(input logic a_valid, input logic b_valid,
                                        input logic prio, input logic open);
        grant_t g;
        g.a = 1'b0;
        g.b = 1'b0;
        if (open) begin
            if (a_valid && (!b_valid || (prio == SEL_A))) begin
                g.a = 1'b1;
            end else if (b_valid) begin
                g.b = 1'b1;
            end else begin
                g.a = 1'b0;
            end
        end else begin
            g.b = 1'b0;
        end
        return g;
    endfunction

endpackage

// File: rtl/rr_merge_stage_sync_fifo.sv
// Synchronous FIFO with registered head; full/empty tracked by an occupancy
// counter so pointer equality never has to be interpreted.
module sync_fifo
    import rr_merge_stage_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Guard the handshakes so the counter can neither overflow nor underflow.
    always_comb begin
        push_ok_s = push && (count_r < CW'(DEPTH));
        pop_ok_s  = pop && (count_r != {CW{1'b0}});
    end

    // Storage, pointers and occupancy; reset clears the array as well.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign count     = count_r;

endmodule

// File: rtl/rr_merge_stage.sv
// Two-input round-robin merge: arbitrates A/B, steers the winner into a small
// FIFO and presents the FIFO head on the X channel.
module rr_merge_stage
    import rr_merge_stage_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         a_data,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [WIDTH-1:0]         b_data,
    input  logic                     b_valid,
    output logic                     b_ready,
    output logic [WIDTH-1:0]         x_data,
    output logic                     x_valid,
    input  logic                     x_ready,
    output logic                     sel,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic             prio_r;
    logic             sel_r;
    grant_t           grant_s;
    logic             push_s;
    logic             pop_s;
    logic [WIDTH-1:0] push_data_s;
    logic [WIDTH-1:0] head_data_s;
    logic [CW-1:0]    count_s;

    // Arbitration and data steering; a draining FIFO does not reopen until the pop lands.
    always_comb begin
        grant_s = rr_grant(a_valid, b_valid, prio_r, (count_s < CW'(DEPTH)) && !rst);
        push_s  = grant_s.a | grant_s.b;
        pop_s   = (count_s != {CW{1'b0}}) && x_ready;
        if (grant_s.b) begin
            push_data_s = b_data;
        end else begin
            push_data_s = a_data;
        end
    end

    // Round-robin priority and last-grant indicator.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_r <= SEL_A;
            sel_r  <= SEL_A;
        end else if (grant_s.a) begin
            prio_r <= SEL_B;
            sel_r  <= SEL_A;
        end else if (grant_s.b) begin
            prio_r <= SEL_A;
            sel_r  <= SEL_B;
        end else begin
            prio_r <= prio_r;
            sel_r  <= sel_r;
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .head_data (head_data_s),
        .count     (count_s)
    );

    assign a_ready = grant_s.a;
    assign b_ready = grant_s.b;
    assign x_valid = (count_s != {CW{1'b0}});
    assign x_data  = head_data_s;
    assign sel     = sel_r;
    assign count   = count_s;

endmodule

// File: tb/tb_rr_merge_stage.sv
// Self-checking bench for rr_merge_stage: directed vector table, hand-written
// corner sequences and random traffic against a queue-based reference model.
module tb_rr_merge_stage;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst, a_valid, b_valid, x_ready;
    logic       a_ready, b_ready, x_valid, sel;
    logic [3:0] a_data, b_data, x_data;
    logic [1:0] count;

    int checks   = 0;
    int failures = 0;

    logic [3:0] q[$];
    logic       m_prio;
    logic       m_sel;

    typedef struct {
        logic       r, av, bv, xr;
        logic [3:0] ad, bd;
        logic       ear, ebr, exv, cxd;
        logic [3:0] exd;
        logic [1:0] ecnt;
        logic       esel;
    } vec_t;

    vec_t vecs[17];

    always #5 clk = ~clk;

    rr_merge_stage #(.WIDTH(4), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
        .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
        .sel(sel), .count(count)
    );

    function automatic vec_t mk(input logic r, input logic av, input logic [3:0] ad,
                                input logic bv, input logic [3:0] bd, input logic xr,
                                input logic ear, input logic ebr, input logic exv,
                                input logic cxd, input logic [3:0] exd,
                                input logic [1:0] ecnt, input logic esel);
        vec_t v;
        v.r = r; v.av = av; v.ad = ad; v.bv = bv; v.bd = bd; v.xr = xr;
        v.ear = ear; v.ebr = ebr; v.exv = exv; v.cxd = cxd; v.exd = exd;
        v.ecnt = ecnt; v.esel = esel;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic av, input logic [3:0] ad,
                         input logic bv, input logic [3:0] bd, input logic xr);
        rst = r; a_valid = av; a_data = ad; b_valid = bv; b_data = bd; x_ready = xr;
    endtask

    // Reference grant: single requester wins, both -> favoured one, nothing if full or in reset.
    task automatic model_grant(output logic ga, output logic gb);
        logic open;
        open = !rst && (q.size() < DEPTH);
        ga = open && a_valid && (!b_valid || (m_prio == 1'b0));
        gb = open && b_valid && (!a_valid || (m_prio == 1'b1));
    endtask

    task automatic model_check(input string tag);
        logic ga, gb;
        model_grant(ga, gb);
        chk({tag, "_a_ready"}, 8'(a_ready), 8'(ga));
        chk({tag, "_b_ready"}, 8'(b_ready), 8'(gb));
        chk({tag, "_x_valid"}, 8'(x_valid), 8'(q.size() != 0));
        chk({tag, "_count"}, 8'(count), 8'(q.size()));
        chk({tag, "_sel"}, 8'(sel), 8'(m_sel));
        if (q.size() != 0) chk({tag, "_x_data"}, 8'(x_data), 8'(q[0]));
    endtask

    task automatic model_edge();
        logic ga, gb;
        model_grant(ga, gb);
        if (rst) begin
            q.delete();
            m_prio = 1'b0;
            m_sel  = 1'b0;
        end else begin
            if (x_ready && q.size() != 0) void'(q.pop_front());
            if (ga) begin q.push_back(a_data); m_prio = 1'b1; m_sel = 1'b0; end
            if (gb) begin q.push_back(b_data); m_prio = 1'b0; m_sel = 1'b1; end
        end
    endtask

    task automatic cycle(input string tag, input logic r, input logic av, input logic [3:0] ad,
                         input logic bv, input logic [3:0] bd, input logic xr);
        drive(r, av, ad, bv, bd, xr);
        #2;
        model_check(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        // Directed table: reset, single source, contention, backpressure until full.
        vecs[0]  = mk(1, 1, 4'h1, 1, 4'h2, 0,  0, 0, 0, 1, 4'h0, 2'd0, 0);
        vecs[1]  = mk(0, 1, 4'hA, 0, 4'h0, 1,  1, 0, 0, 1, 4'h0, 2'd0, 0);
        vecs[2]  = mk(0, 0, 4'h0, 0, 4'h0, 1,  0, 0, 1, 1, 4'hA, 2'd1, 0);
        vecs[3]  = mk(0, 0, 4'h0, 1, 4'h2, 1,  0, 1, 0, 0, 4'h0, 2'd0, 0);
        vecs[4]  = mk(0, 1, 4'h1, 1, 4'h2, 1,  1, 0, 1, 1, 4'h2, 2'd1, 1);
        vecs[5]  = mk(0, 1, 4'h1, 1, 4'h2, 1,  0, 1, 1, 1, 4'h1, 2'd1, 0);
        vecs[6]  = mk(0, 1, 4'h1, 1, 4'h2, 1,  1, 0, 1, 1, 4'h2, 2'd1, 1);
        vecs[7]  = mk(0, 1, 4'h1, 1, 4'h2, 1,  0, 1, 1, 1, 4'h1, 2'd1, 0);
        vecs[8]  = mk(0, 0, 4'h0, 0, 4'h0, 1,  0, 0, 1, 1, 4'h2, 2'd1, 1);
        vecs[9]  = mk(0, 1, 4'h1, 1, 4'h2, 0,  1, 0, 0, 0, 4'h0, 2'd0, 1);
        vecs[10] = mk(0, 1, 4'h1, 1, 4'h2, 0,  0, 1, 1, 1, 4'h1, 2'd1, 0);
        vecs[11] = mk(0, 1, 4'h1, 1, 4'h2, 0,  0, 0, 1, 1, 4'h1, 2'd2, 1);
        vecs[12] = mk(0, 1, 4'h1, 1, 4'h2, 1,  0, 0, 1, 1, 4'h1, 2'd2, 1);
        vecs[13] = mk(0, 1, 4'h1, 1, 4'h2, 0,  1, 0, 1, 1, 4'h2, 2'd1, 1);
        vecs[14] = mk(0, 0, 4'h0, 0, 4'h0, 1,  0, 0, 1, 1, 4'h2, 2'd2, 0);
        vecs[15] = mk(0, 0, 4'h0, 0, 4'h0, 1,  0, 0, 1, 1, 4'h1, 2'd1, 0);
        vecs[16] = mk(0, 0, 4'h0, 0, 4'h0, 0,  0, 0, 0, 0, 4'h0, 2'd0, 0);

        drive(1, 1, 4'h1, 1, 4'h2, 0);
        q.delete(); m_prio = 1'b0; m_sel = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].r, vecs[i].av, vecs[i].ad, vecs[i].bv, vecs[i].bd, vecs[i].xr);
            #2;
            chk($sformatf("vec%0d_a_ready", i), 8'(a_ready), 8'(vecs[i].ear));
            chk($sformatf("vec%0d_b_ready", i), 8'(b_ready), 8'(vecs[i].ebr));
            chk($sformatf("vec%0d_x_valid", i), 8'(x_valid), 8'(vecs[i].exv));
            chk($sformatf("vec%0d_count", i), 8'(count), 8'(vecs[i].ecnt));
            chk($sformatf("vec%0d_sel", i), 8'(sel), 8'(vecs[i].esel));
            if (vecs[i].cxd) chk($sformatf("vec%0d_x_data", i), 8'(x_data), 8'(vecs[i].exd));
            @(posedge clk);
            #1;
        end

        // Push and pop together at count=1 across several pointer wraps.
        cycle("t5_rst", 1, 0, 4'h0, 0, 4'h0, 0);
        cycle("t5_first", 0, 1, 4'h0, 0, 4'h0, 1);
        for (int i = 1; i < 8; i++) begin
            cycle("t5", 0, 1, 4'(i), 0, 4'h0, 1);
            chk("t5_count", 8'(count), 8'd1);
            chk("t5_order", 8'(x_data), 8'(i));
        end
        cycle("t5_drain", 0, 0, 4'h0, 0, 4'h0, 1);

        // Reset while holding two words; priority must return to A.
        cycle("t6_fill0", 0, 1, 4'h3, 0, 4'h0, 0);
        cycle("t6_fill1", 0, 1, 4'h4, 0, 4'h0, 0);
        chk("t6_full_count", 8'(count), 8'd2);
        cycle("t6_rst", 1, 1, 4'h5, 1, 4'h6, 1);
        chk("t6_rst_count", 8'(count), 8'd0);
        chk("t6_rst_x_valid", 8'(x_valid), 8'd0);
        chk("t6_rst_x_data", 8'(x_data), 8'd0);
        drive(0, 1, 4'h7, 1, 4'h8, 1);
        #2;
        chk("t6_grant_a", 8'(a_ready), 8'd1);
        chk("t6_no_grant_b", 8'(b_ready), 8'd0);
        @(posedge clk);
        model_edge();
        #1;

        // Random traffic with occasional resets against the queue model.
        for (int i = 0; i < 400; i++) begin
            cycle("rnd", ($urandom_range(0, 49) == 0), 1'($urandom), 4'($urandom),
                  1'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
